dma_reg_engine: RTL and testbench
=================================

// Module: dma_reg_engine
// PURPOSE
// - Bus-side consumer of the dma_if transaction stream; sits directly downstream of the bus driver.
// - Decodes valid/wr_en/addr/wdata into a memory-mapped DMA register file and returns rdata.
// - A transfer engine issues one word-copy request per handshake and raises a maskable interrupt.
// PARAMETERS
// BASE_ADDR  32'h400  byte address of the first register; registers are at BASE_ADDR+{0x0,0x4,0x8,0xC,0x10}
// CNT_W      16       width of the transfer length and remaining-count fields (max 16)
// ADDR_STEP  4        byte increment applied to both addresses after each completed word
// PORTS
// clk        in   1   clock; all logic on posedge
// reset      in   1   asynchronous, active-high reset
// addr       in   32  register byte address; sampled when valid=1
// wr_en      in   1   1=write, 0=read; sampled when valid=1
// valid      in   1   one-cycle transaction strobe; a new transaction is allowed every cycle
// wdata      in   32  write data
// rdata      out  32  read data, registered
// xfer_req   out  1   word-copy request to the memory side
// xfer_src   out  32  current source (IO) address
// xfer_dst   out  32  current destination (MEM) address
// xfer_ack   in   1   memory side accepted the current word
// irq        out  1   |(INTR.status & INTR.mask), registered
// BEHAVIOUR
// - Reset: every register, rdata, xfer_req, xfer_src, xfer_dst and irq go to 0; FSM goes to IDLE.
//   A reset during XFER drops xfer_req immediately; no completion interrupt is raised.
// - Registers:
//   +0x0  INTR      [15:0] status, write-1-to-clear; [31:16] mask, RW.
//                   Status bits: 0=DONE, 1=ABORTED, 2=START_WHILE_BUSY.
//   +0x4  CTRL      [0] START, self-clearing; [1] ABORT, self-clearing; [31:16] LEN in words, RW.
//                   START and ABORT read as 0.
//   +0x8  IO_ADDR   RW
//   +0xC  MEM_ADDR  RW
//   +0x10 STATUS    RO; [0] busy; [31:16] remaining words. Writes are ignored.
// - Read: valid=1 and wr_en=0 in cycle N -> rdata holds the register value in cycle N+1.
//   rdata holds its last value when there is no read. An unmapped address returns 32'h0.
// - Write: takes effect at the posedge where valid=1. A write to an unmapped address has no effect.
//   While busy, writes to IO_ADDR, MEM_ADDR and CTRL.LEN are ignored.
//   START and ABORT writes are always processed.
// - FSM IDLE:
//   START=1 with LEN!=0 -> load xfer_src=IO_ADDR, xfer_dst=MEM_ADDR, remaining=LEN; go to XFER.
//   START=1 with LEN==0 -> go to DONE directly.
// - FSM XFER:
//   xfer_req=1 from the cycle after entry.
//   On each xfer_ack with xfer_req=1: src+=ADDR_STEP, dst+=ADDR_STEP, remaining-=1.
//   When the last word is acked: xfer_req=0 in the next cycle; go to DONE.
//   xfer_ack while xfer_req=0 is ignored.
//   Addresses wrap modulo 2^32; the carry is discarded.
// - FSM ABORT while in XFER: go to IDLE next cycle; xfer_req=0; set ABORTED; remaining keeps its value.
//   If ABORT and the final ack land in the same cycle, the ack completes and DONE wins.
// - FSM DONE: one cycle; set status.DONE; return to IDLE. busy=1 in XFER and DONE only.
// - START while busy: ignored; sets status bit 2.
// - Status set and W1C in the same cycle: set wins.
// - irq is updated one cycle after status or mask changes.
// TESTING
// - Reset state:
//   assert reset mid-run -> rdata, irq and xfer_req = 0 immediately; STATUS reads 0x0 after release.
// - Register R/W:
//   write IO_ADDR=0x1000_0000, MEM_ADDR=0x2000_0000, then read both
//   -> rdata 0x1000_0000 and 0x2000_0000, each one cycle after its valid.
//   Read 0x500 -> 0x0.
// - Transfer:
//   LEN=3, mask bit0=1, START, ack on every cycle
//   -> exactly 3 acked requests, src 0x1000_0000/04/08;
//   STATUS goes busy then 0; INTR reads 0x0001_0001; irq=1.
// - W1C:
//   write INTR=0x0001_0001 -> status clears, mask stays set; irq=0 next cycle.
// - Abort/busy:
//   LEN=8, START, ack 2 words, then START -> INTR bit2=1.
//   Then ABORT -> xfer_req=0; STATUS remaining=6; INTR bit1=1; DONE=0.
// - Zero and wrap:
//   LEN=0 START -> DONE set with no xfer_req.
//   IO_ADDR=0xFFFF_FFFC, LEN=2 -> second src=0x0000_0000.

Source files
------------

// File: rtl/dma_reg_engine.sv
// dma_reg_engine
//   Memory-mapped DMA register file with a single-channel word-copy engine.
//   Sits downstream of the bus driver. It decodes valid/wr_en/addr/wdata
//   transactions and returns registered read data. On START it issues one
//   xfer_req per word and advances the source and destination addresses
//   on each accepted word. It raises a maskable interrupt on completion,
//   on abort and on a START received while busy.
//
// Ports
//   clk       in   clock, all logic on posedge
//   reset     in   asynchronous active-high reset
//   addr      in   register byte address, sampled when valid=1
//   wr_en     in   1=write, 0=read, sampled when valid=1
//   valid     in   one-cycle transaction strobe
//   wdata     in   write data
//   rdata     out  registered read data
//   xfer_req  out  word-copy request to the memory side
//   xfer_src  out  current source (IO) address
//   xfer_dst  out  current destination (MEM) address
//   xfer_ack  in   memory side accepted the current word
//   irq       out  registered |(INTR.status & INTR.mask)
//
// Register map (byte offsets from BASE_ADDR)
//   0x00 INTR      [15:0] status W1C (0=DONE 1=ABORTED 2=START_WHILE_BUSY), [31:16] mask
//   0x04 CTRL      [0] START, [1] ABORT (both self-clearing, read 0), [31:16] LEN
//   0x08 IO_ADDR
//   0x0C MEM_ADDR
//   0x10 STATUS    RO, [0] busy, [31:16] remaining words
module dma_reg_engine #(
  parameter logic [31:0] BASE_ADDR = 32'h400,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        valid,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        xfer_req,
  output logic [31:0] xfer_src,
  output logic [31:0] xfer_dst,
  input  logic        xfer_ack,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        status_q, status_d;
  logic [15:0]        mask_q, mask_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [31:0]        io_addr_q, io_addr_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               req_q, req_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;

  logic               wr, rd, busy;
  logic               sel_intr, sel_ctrl, sel_io, sel_mem, sel_stat;
  logic               start_wr, abort_wr, ack_ok;
  logic [CNT_W-1:0]   eff_len;
  logic [15:0]        status_set, status_clr;

  assign wr       = valid & wr_en;
  assign rd       = valid & ~wr_en;
  assign sel_intr = (addr == BASE_ADDR);
  assign sel_ctrl = (addr == BASE_ADDR + 32'h4);
  assign sel_io   = (addr == BASE_ADDR + 32'h8);
  assign sel_mem  = (addr == BASE_ADDR + 32'hC);
  assign sel_stat = (addr == BASE_ADDR + 32'h10);
  assign busy     = (state_q != ST_IDLE);
  assign start_wr = wr & sel_ctrl & wdata[0];
  assign abort_wr = wr & sel_ctrl & wdata[1];
  assign ack_ok   = xfer_ack & req_q;

  // A CTRL write carrying START in IDLE also carries the LEN it starts with.
  assign eff_len  = (wr && sel_ctrl && !busy) ? wdata[16 +: CNT_W] : len_q;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    len_d      = len_q;
    io_addr_d  = io_addr_q;
    mem_addr_d = mem_addr_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    status_set = '0;
    status_clr = '0;

    if (wr && sel_intr) begin
      mask_d     = wdata[31:16];
      status_clr = wdata[15:0];
    end
    if (wr && !busy) begin
      if (sel_ctrl) len_d      = wdata[16 +: CNT_W];
      if (sel_io)   io_addr_d  = wdata;
      if (sel_mem)  mem_addr_d = wdata;
    end

    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        if (start_wr) begin
          if (eff_len != '0) begin
            src_d   = io_addr_q;
            dst_d   = mem_addr_q;
            rem_d   = eff_len;
            state_d = ST_XFER;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_XFER: begin
        if (start_wr) status_set[2] = 1'b1;
        if (ack_ok) begin
          src_d = src_q + 32'(ADDR_STEP);
          dst_d = dst_q + 32'(ADDR_STEP);
          rem_d = rem_q - CNT_W'(1);
        end
        // The final ack completes the transfer even if ABORT arrives with it.
        if (ack_ok && rem_q == CNT_W'(1)) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (abort_wr) begin
          req_d         = 1'b0;
          status_set[1] = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_DONE: begin
        req_d         = 1'b0;
        status_set[0] = 1'b1;
        if (start_wr) status_set[2] = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Hardware set takes priority over a same-cycle write-1-to-clear.
    status_d = (status_q & ~status_clr) | status_set;
    irq_d    = |(status_q & mask_q);

    if (rd) begin
      if (sel_intr)      rdata_d = {mask_q, status_q};
      else if (sel_ctrl) rdata_d = {16'(len_q), 16'h0};
      else if (sel_io)   rdata_d = io_addr_q;
      else if (sel_mem)  rdata_d = mem_addr_q;
      else if (sel_stat) rdata_d = {16'(rem_q), 15'h0, busy};
      else               rdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      status_q   <= '0;
      mask_q     <= '0;
      len_q      <= '0;
      io_addr_q  <= '0;
      mem_addr_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      req_q      <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      mask_q     <= mask_d;
      len_q      <= len_d;
      io_addr_q  <= io_addr_d;
      mem_addr_q <= mem_addr_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata    = rdata_q;
  assign xfer_req = req_q;
  assign xfer_src = src_q;
  assign xfer_dst = dst_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_dma_reg_engine.sv
// tb_dma_reg_engine
//   Directed bench for dma_reg_engine. Inputs are driven and outputs sampled
//   on the falling clock edge so every registered result is stable.
module tb_dma_reg_engine;

  localparam logic [31:0] B = 32'h400;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        wr_en;
  logic        valid;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        xfer_req;
  logic [31:0] xfer_src;
  logic [31:0] xfer_dst;
  logic        xfer_ack;
  logic        irq;

  int errors = 0;
  int checks = 0;

  dma_reg_engine #(.BASE_ADDR(32'h400), .CNT_W(16), .ADDR_STEP(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wr_en    (wr_en),
    .valid    (valid),
    .wdata    (wdata),
    .rdata    (rdata),
    .xfer_req (xfer_req),
    .xfer_src (xfer_src),
    .xfer_dst (xfer_dst),
    .xfer_ack (xfer_ack),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; wr_en = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdata, irq, xfer_req, xfer_src, xfer_dst} !== 98'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h irq=%b req=%b src=%h dst=%h, required all 0",
               rdata, irq, xfer_req, xfer_src, xfer_dst);
    end
    reset = 1'b0;
    bus_read(B + 32'h10, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required %h", d, 32'h0); end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    bus_write(B + 32'h8, 32'h1000_0000);
    bus_write(B + 32'hC, 32'h2000_0000);
    bus_read(B + 32'h8, d);
    checks++;
    if (d !== 32'h1000_0000) begin errors++; $display("FAIL rd_io_addr: got %h required %h", d, 32'h1000_0000); end
    @(negedge clk);
    checks++;
    if (rdata !== 32'h1000_0000) begin errors++; $display("FAIL rdata_hold: got %h required %h", rdata, 32'h1000_0000); end
    bus_read(B + 32'hC, d);
    checks++;
    if (d !== 32'h2000_0000) begin errors++; $display("FAIL rd_mem_addr: got %h required %h", d, 32'h2000_0000); end
    bus_read(32'h500, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rd_unmapped: got %h required %h", d, 32'h0); end
  endtask

  task automatic test_transfer;
    logic [31:0] d;
    logic [31:0] srcs[$];
    logic [31:0] dsts[$];
    xfer_ack = 1'b0;
    bus_write(B + 32'h0, 32'h0001_0000);
    bus_write(B + 32'h4, 32'h0003_0001);
    bus_read(B + 32'h10, d);
    checks++;
    if (d !== 32'h0003_0001) begin errors++; $display("FAIL xfer_status_busy: got %h required %h", d, 32'h0003_0001); end
    xfer_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (xfer_req) begin srcs.push_back(xfer_src); dsts.push_back(xfer_dst); end
      @(negedge clk);
    end
    xfer_ack = 1'b0;
    checks++;
    if (srcs.size() != 3) begin
      errors++; $display("FAIL xfer_count: got %0d required %0d", srcs.size(), 3);
    end else begin
      checks++;
      if ({srcs[0], srcs[1], srcs[2]} !== {32'h1000_0000, 32'h1000_0004, 32'h1000_0008}) begin
        errors++; $display("FAIL xfer_src_seq: got %h %h %h required 10000000 10000004 10000008",
                           srcs[0], srcs[1], srcs[2]);
      end
      checks++;
      if (dsts[2] !== 32'h2000_0008) begin errors++; $display("FAIL xfer_dst_last: got %h required %h", dsts[2], 32'h2000_0008); end
    end
    bus_read(B + 32'h10, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL xfer_status_idle: got %h required %h", d, 32'h0); end
    bus_read(B + 32'h0, d);
    checks++;
    if (d !== 32'h0001_0001) begin errors++; $display("FAIL xfer_intr: got %h required %h", d, 32'h0001_0001); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL xfer_irq: got %b required 1", irq); end
  endtask

  task automatic test_w1c;
    logic [31:0] d;
    bus_write(B + 32'h0, 32'h0001_0001);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_lag: got %b required 1", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b required 0", irq); end
    bus_read(B + 32'h0, d);
    checks++;
    if (d !== 32'h0001_0000) begin errors++; $display("FAIL w1c_intr: got %h required %h", d, 32'h0001_0000); end
  endtask

  task automatic test_abort_busy;
    logic [31:0] d;
    bit seen;
    xfer_ack = 1'b0;
    bus_write(B + 32'h8, 32'h1000_0000);
    bus_write(B + 32'h4, 32'h0008_0001);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (xfer_req) seen = 1'b1; else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_req_timeout: got req=0 required req=1 within 10 cycles"); end
    xfer_ack = 1'b1;
    repeat (2) @(negedge clk);
    xfer_ack = 1'b0;
    checks++;
    if (xfer_src !== 32'h1000_0008) begin errors++; $display("FAIL abort_src_after2: got %h required %h", xfer_src, 32'h1000_0008); end
    bus_write(B + 32'h4, 32'h0000_0001);
    bus_read(B + 32'h0, d);
    checks++;
    if (d !== 32'h0001_0004) begin errors++; $display("FAIL busy_start_intr: got %h required %h", d, 32'h0001_0004); end
    bus_read(B + 32'h4, d);
    checks++;
    if (d !== 32'h0008_0000) begin errors++; $display("FAIL busy_len_kept: got %h required %h", d, 32'h0008_0000); end
    bus_write(B + 32'h4, 32'h0000_0002);
    checks++;
    if (xfer_req !== 1'b0) begin errors++; $display("FAIL abort_req: got %b required 0", xfer_req); end
    bus_read(B + 32'h10, d);
    checks++;
    if (d !== 32'h0006_0000) begin errors++; $display("FAIL abort_status: got %h required %h", d, 32'h0006_0000); end
    bus_read(B + 32'h0, d);
    checks++;
    if (d !== 32'h0001_0006) begin errors++; $display("FAIL abort_intr: got %h required %h", d, 32'h0001_0006); end
    bus_write(B + 32'h0, 32'h0001_0007);
  endtask

  task automatic test_zero_wrap;
    logic [31:0] d;
    logic [31:0] srcs[$];
    bit req_seen;
    xfer_ack = 1'b0;
    bus_write(B + 32'h4, 32'h0000_0001);
    req_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (xfer_req) req_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (req_seen) begin errors++; $display("FAIL zero_len_req: got req=1 required req=0"); end
    bus_read(B + 32'h0, d);
    checks++;
    if (d !== 32'h0001_0001) begin errors++; $display("FAIL zero_len_done: got %h required %h", d, 32'h0001_0001); end
    bus_write(B + 32'h0, 32'h0001_0007);
    bus_write(B + 32'h8, 32'hFFFF_FFFC);
    xfer_ack = 1'b1;
    bus_write(B + 32'h4, 32'h0002_0001);
    for (int i = 0; i < 10; i++) begin
      if (xfer_req) srcs.push_back(xfer_src);
      @(negedge clk);
    end
    xfer_ack = 1'b0;
    checks++;
    if (srcs.size() != 2) begin
      errors++; $display("FAIL wrap_count: got %0d required %0d", srcs.size(), 2);
    end else begin
      checks++;
      if ({srcs[0], srcs[1]} !== {32'hFFFF_FFFC, 32'h0000_0000}) begin
        errors++; $display("FAIL wrap_src: got %h %h required fffffffc 00000000", srcs[0], srcs[1]);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] d;
    bit seen;
    bus_read(B + 32'h8, d);
    bus_write(B + 32'h4, 32'h0004_0001);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (xfer_req) seen = 1'b1; else @(negedge clk);
    end
    checks++;
    if (!seen || rdata !== 32'hFFFF_FFFC || irq !== 1'b1) begin
      errors++; $display("FAIL midrst_setup: got req=%b rdata=%h irq=%b required 1 fffffffc 1", xfer_req, rdata, irq);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({rdata, irq, xfer_req} !== 34'h0) begin
      errors++; $display("FAIL midrst_async: got rdata=%h irq=%b req=%b required 0 0 0", rdata, irq, xfer_req);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (xfer_req !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL midrst_after: got req=%b irq=%b required 0 0", xfer_req, irq);
    end
    bus_read(B + 32'h10, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midrst_status: got %h required %h", d, 32'h0); end
    bus_read(B + 32'h0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midrst_intr: got %h required %h", d, 32'h0); end
  endtask

  initial begin
    reset    = 1'b1;
    addr     = '0;
    wr_en    = 1'b0;
    valid    = 1'b0;
    wdata    = '0;
    xfer_ack = 1'b0;
    test_reset();
    test_regs();
    test_transfer();
    test_w1c();
    test_abort_busy();
    test_zero_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
